// File: rtl/pair_stream_loader.sv
// Byte-pair stream loader: packs (addr, data) byte pairs into 16-bit words, writes them
// sequentially from BASE_ADDR, then hands the batch word count to the transfer FSM.
module pair_stream_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        batch_valid,
  output logic [15:0] batch_words,
  input  logic        batch_ack,
  output logic        err_odd,
  output logic        err_full,
  input  logic        clr_err
);

  typedef enum logic [1:0] {HI, LO, WR, DONE} state_e;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_e      state_q, state_d;
  logic [16:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]  addr_q;
  logic        last_q;
  logic        mem_we_q;
  logic [15:0] mem_addr_q, mem_wdata_q;
  logic        batch_valid_q;
  logic [15:0] batch_words_q;
  logic        err_odd_q, err_full_q;

  logic        accept, room;
  logic        set_odd, set_full, we_d;
  logic [15:0] words_sat;

  assign accept    = s_valid && s_ready;
  assign room      = (wr_ptr_q < DEPTH_W);
  assign words_sat = (wr_ptr_d > 17'h0FFFF) ? 16'hFFFF : wr_ptr_d[15:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= HI;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    unique case (state_q)
      HI: begin
        if (accept) begin
          if (s_last) state_d = (wr_ptr_q != '0) ? DONE : HI;
          else        state_d = LO;
        end
      end
      LO: begin
        if (accept) state_d = WR;
      end
      WR: begin
        if (room) wr_ptr_d = wr_ptr_q + 17'd1;
        // A full memory closes the batch even if the pair was not the last one.
        state_d = (last_q || !room) ? DONE : HI;
      end
      DONE: begin
        if (batch_ack) begin
          wr_ptr_d = '0;
          state_d  = HI;
        end
      end
      default: state_d = HI;
    endcase
  end

  always_comb begin
    s_ready  = !rst && ((state_q == HI) || (state_q == LO));
    set_odd  = (state_q == HI) && accept && s_last;
    set_full = (state_q == WR) && !room;
    // Write strobe is prepared while the data byte is accepted so it lands in the WR cycle.
    we_d     = (state_q == LO) && accept && room;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      addr_q        <= '0;
      last_q        <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      batch_valid_q <= 1'b0;
      batch_words_q <= '0;
      err_odd_q     <= 1'b0;
      err_full_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      if ((state_q == HI) && accept) addr_q <= s_data;
      if ((state_q == LO) && accept) begin
        last_q      <= s_last;
        mem_addr_q  <= BASE_ADDR + wr_ptr_q[15:0];
        mem_wdata_q <= {addr_q, s_data};
      end
      mem_we_q      <= we_d;
      batch_valid_q <= (state_d == DONE);
      batch_words_q <= (state_d == DONE) ? words_sat : '0;
      if (set_odd)      err_odd_q <= 1'b1;
      else if (clr_err) err_odd_q <= 1'b0;
      if (set_full)     err_full_q <= 1'b1;
      else if (clr_err) err_full_q <= 1'b0;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign batch_valid = batch_valid_q;
  assign batch_words = batch_words_q;
  assign err_odd     = err_odd_q;
  assign err_full    = err_full_q;

endmodule

// File: tb/tb_pair_stream_loader.sv
// Bench for pair_stream_loader: directed scenarios with literal expectations plus random
// batches, all checked every cycle against a pair/batch-level reference model.
module tb_pair_stream_loader;

  localparam logic [15:0] BASE  = 16'h0A00;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        batch_valid;
  logic [15:0] batch_words;
  logic        batch_ack, clr_err;
  logic        err_odd, err_full;

  logic ack_dir = 1'b0, ack_rnd = 1'b0, clr_dir = 1'b0, clr_rnd = 1'b0;
  logic auto_mode = 1'b0;
  logic chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  assign batch_ack = ack_dir | ack_rnd;
  assign clr_err   = clr_dir | clr_rnd;

  always #5 clk = ~clk;

  pair_stream_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .batch_valid(batch_valid), .batch_words(batch_words), .batch_ack(batch_ack),
    .err_odd(err_odd), .err_full(err_full), .clr_err(clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks half-built pair, the one-cycle write slot and the pending batch.
  bit          m_have, m_wr, m_wrlast, m_pend, m_we, m_eodd, m_efull;
  logic [7:0]  m_a;
  int          m_words;
  logic [15:0] m_addr, m_data;

  always @(negedge clk) begin
    logic exp_ready;
    bit   set_odd, set_full, nwe;
    exp_ready = !rst && !m_wr && !m_pend;
    if (chk_en) begin
      chk("s_ready", {31'd0, s_ready}, {31'd0, exp_ready});
      chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
      if (m_we) begin
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
        chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, m_data});
      end
      chk("batch_valid", {31'd0, batch_valid}, {31'd0, m_pend});
      if (m_pend) chk("batch_words", {16'd0, batch_words}, (m_words > 65535) ? 32'hFFFF : m_words);
      chk("err_odd", {31'd0, err_odd}, {31'd0, m_eodd});
      chk("err_full", {31'd0, err_full}, {31'd0, m_efull});
    end
    if (rst) begin
      m_have = 0; m_wr = 0; m_wrlast = 0; m_pend = 0; m_we = 0;
      m_eodd = 0; m_efull = 0; m_words = 0;
    end else begin
      set_odd = 0; set_full = 0; nwe = 0;
      if (m_wr) begin
        m_wr = 0;
        if (m_words < DEPTH) m_words++;
        else set_full = 1;
        if (m_wrlast || set_full) m_pend = 1;
      end else if (m_pend) begin
        if (batch_ack) begin
          m_pend = 0;
          m_words = 0;
        end
      end else if (s_valid) begin
        if (!m_have) begin
          if (s_last) begin
            set_odd = 1;
            if (m_words > 0) m_pend = 1;
          end else begin
            m_have = 1;
            m_a = s_data;
          end
        end else begin
          m_have = 0;
          m_wr = 1;
          m_wrlast = s_last;
          nwe = (m_words < DEPTH);
          m_addr = 16'(BASE + m_words);
          m_data = {m_a, s_data};
        end
      end
      m_we = nwe;
      if (set_odd) m_eodd = 1; else if (clr_err) m_eodd = 0;
      if (set_full) m_efull = 1; else if (clr_err) m_efull = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    ack_rnd = auto_mode && ($urandom_range(0, 2) == 0);
    clr_rnd = auto_mode && ($urandom_range(0, 15) == 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last, output int cyc);
    logic acc;
    acc = 1'b0;
    cyc = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = s_ready;
      tick();
      cyc++;
      if (acc) break;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout: byte %h never accepted", d);
    end
    if (last) s_valid = 1'b0;
  endtask

  task automatic ack_pulse();
    ack_dir = 1'b1; tick(); ack_dir = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_dir = 1'b1; tick(); clr_dir = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, sum, n;
    bit odd;
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_batch_valid", {31'd0, batch_valid}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_err", {30'd0, err_odd, err_full}, 32'd0);

    // T1 single pair
    send(8'h12, 1'b0, c);
    send(8'h34, 1'b1, c);
    chk("t1_we", {31'd0, mem_we}, 32'd1);
    chk("t1_addr", {16'd0, mem_addr}, 32'h0A00);
    chk("t1_wdata", {16'd0, mem_wdata}, 32'h1234);
    tick();
    chk("t1_valid", {31'd0, batch_valid}, 32'd1);
    chk("t1_words", {16'd0, batch_words}, 32'd1);
    ack_pulse();

    // T2 four pairs, s_valid stuck high: ready pattern 1,1,0 gives 11 waited cycles
    sum = 0;
    for (int p = 0; p < 4; p++) begin
      send(8'(8'h40 + p), 1'b0, c); sum += c;
      send(8'(8'h80 + p), (p == 3), c); sum += c;
    end
    chk("t2_cycles", sum, 32'd11);
    chk("t2_last_addr", {16'd0, mem_addr}, 32'h0A03);
    chk("t2_last_wdata", {16'd0, mem_wdata}, 32'h4383);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t2_words", {16'd0, batch_words}, 32'd4);
      tick();
    end
    ack_pulse();

    // T3 odd last
    send(8'hAA, 1'b0, c);
    send(8'hBB, 1'b0, c);
    chk("t3_wdata", {16'd0, mem_wdata}, 32'hAABB);
    send(8'hCC, 1'b1, c);
    chk("t3_err_odd", {31'd0, err_odd}, 32'd1);
    chk("t3_valid", {31'd0, batch_valid}, 32'd1);
    chk("t3_words", {16'd0, batch_words}, 32'd1);
    ack_pulse();
    clr_pulse();
    chk("t3_cleared", {31'd0, err_odd}, 32'd0);
    send(8'h01, 1'b1, c);
    chk("t3_lone_err", {31'd0, err_odd}, 32'd1);
    chk("t3_lone_novalid", {31'd0, batch_valid}, 32'd0);
    chk("t3_lone_ready", {31'd0, s_ready}, 32'd1);
    clr_pulse();

    // T4 overflow: DEPTH+1 pairs
    for (int p = 0; p < 5; p++) begin
      send(8'(8'h10 + p), 1'b0, c);
      send(8'(8'h20 + p), (p == 4), c);
    end
    chk("t4_no_write", {31'd0, mem_we}, 32'd0);
    tick();
    chk("t4_full", {31'd0, err_full}, 32'd1);
    chk("t4_words", {16'd0, batch_words}, 32'd4);

    // T5 ack held off for 10 cycles
    for (int k = 0; k < 10; k++) begin
      chk("t5_ready", {31'd0, s_ready}, 32'd0);
      chk("t5_valid", {31'd0, batch_valid}, 32'd1);
      tick();
    end
    ack_pulse();
    clr_pulse();
    chk("t4_clr", {30'd0, err_odd, err_full}, 32'd0);
    send(8'h21, 1'b0, c);
    send(8'h43, 1'b1, c);
    chk("t5_restart_addr", {16'd0, mem_addr}, 32'h0A00);
    chk("t5_restart_wdata", {16'd0, mem_wdata}, 32'h2143);
    tick();
    ack_pulse();

    // T6 reset after the first byte of a pair
    send(8'h55, 1'b0, c);
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_ready_rst", {31'd0, s_ready}, 32'd0);
    tick();
    rst = 1'b0;
    send(8'h66, 1'b0, c);
    send(8'h77, 1'b1, c);
    chk("t6_we", {31'd0, mem_we}, 32'd1);
    chk("t6_addr", {16'd0, mem_addr}, 32'h0A00);
    chk("t6_wdata", {16'd0, mem_wdata}, 32'h6677);
    tick();
    ack_pulse();

    // Random batches with gaps, random ack/clear and occasional odd trailing byte
    auto_mode = 1'b1;
    for (int b = 0; b < 40; b++) begin
      n = $urandom_range(1, 6);
      odd = ($urandom_range(0, 7) == 0);
      for (int p = 0; p < n; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          s_valid = 1'b0;
          repeat ($urandom_range(1, 3)) tick();
        end
        send(8'($urandom), 1'b0, c);
        if ($urandom_range(0, 3) == 0) begin
          s_valid = 1'b0;
          repeat ($urandom_range(1, 3)) tick();
        end
        send(8'($urandom), (p == n - 1) && !odd, c);
      end
      if (odd) send(8'($urandom), 1'b1, c);
    end
    s_valid = 1'b0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
